// File: rtl/bec_pkg.sv
// Shared constants and state encoding for the BEC GF(2^163) arithmetic blocks.
package bec_pkg;

  localparam int unsigned M        = 163;
  localparam int unsigned CNT_W    = 8;
  localparam logic [M-1:0] RED_POLY = 163'h0C9;

  // Encodings are shared with the ladder controller, so keep them explicit.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b11;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

endpackage

// File: rtl/bec_gf2m_mulx_add.sv
// One MSB-first multiply step: c_o = c_i*x mod f XOR (b_i ? a_i : 0).
module bec_gf2m_mulx_add #(
  parameter int unsigned       Width   = 163,
  parameter logic [Width-1:0] RedPoly = 163'h0C9
) (
  input  logic [Width-1:0] c_i,
  input  logic [Width-1:0] a_i,
  input  logic             b_i,
  output logic [Width-1:0] c_o
);

  always_comb begin
    c_o = {c_i[Width-2:0], 1'b0};
    if (c_i[Width-1]) c_o = c_o ^ RedPoly;
    if (b_i)          c_o = c_o ^ a_i;
  end

endmodule

// File: rtl/bec_gf2m_mult.sv
// Bit-serial GF(2^163) multiplier, polynomial basis, one operand bit per cycle,
// with a 4-phase start/done handshake.
module bec_gf2m_mult #(
  parameter int unsigned   M        = bec_pkg::M,
  parameter logic [M-1:0] RED_POLY = bec_pkg::RED_POLY,
  parameter int unsigned   CNT_W    = bec_pkg::CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] a_i,
  input  logic [M-1:0] b_i,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] result
);
  import bec_pkg::*;

  state_e             state_q, state_d;
  logic [M-1:0]       a_q, a_d, b_q, b_d, c_q, c_d, res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               armed_q, armed_d;
  logic [M-1:0]       c_next;

  bec_gf2m_mulx_add #(
    .Width  (M),
    .RedPoly(RED_POLY)
  ) u_mulx_add (
    .c_i(c_q),
    .a_i(a_q),
    .b_i(b_q[cnt_q]),
    .c_o(c_next)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        if (!start) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          a_d     = a_i;
          b_d     = b_i;
          c_d     = '0;
          cnt_d   = CNT_W'(M - 1);
          state_d = StRun;
        end
      end
      StRun: begin
        busy = 1'b1;
        c_d  = c_next;
        if (cnt_q == '0) begin
          res_d   = c_next;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        done = 1'b1;
        // Re-arm only once start is seen low, so a held start cannot retrigger.
        armed_d = !start;
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign result = res_q;

endmodule
